// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS control sequencer.
//   - mc_state_e : FSM state encodings (also exposed on the 'state' port)
//   - OP_*       : instr[31:26] opcodes the sequencer understands
//   - ALUOP_*, SRCB_*, PCSRC_* : datapath mux / ALU control encodings
//   - is_wait_state() : states that stall on mem_ready
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDIEX   = 4'd11,
    S_ADDIWB   = 4'd12,
    S_HALT     = 4'd13
  } mc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that issue a memory access and stall until mem_ready.
  function automatic logic is_wait_state(input mc_state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts consecutive stalled cycles in a memory state.
// Ports:
//   clk     in  system clock, rising edge
//   reset   in  asynchronous active-low reset
//   clear   in  zero the counter (has priority over enable)
//   enable  in  a stalled cycle: count it and test against the limit
//   expire  out high in the stalled cycle that reaches WAIT_MAX waits
// WAIT_MAX = 0 disables expiry; the counter then simply wraps.
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [WAIT_W-1:0] LIMIT = (WAIT_MAX > 0) ? WAIT_W'(WAIT_MAX - 1) : '0;

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The count holds the number of earlier stalled cycles, so the stall that
  // sees LIMIT is the WAIT_MAX-th one.
  assign expire = (WAIT_MAX > 0) && enable && (count_q == LIMIT);

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore control sequencer for the multicycle MIPS datapath
// (R-type, lw, sw, beq, j, addi) with variable-latency shared memory.
// Ports:
//   clk, reset (async, active-low)        clock / reset
//   opcode[5:0], mem_ready                instruction opcode, memory handshake
//   PCWrite .. ALUSrcA, ALUSrcB, ALUOp,   datapath controls, decoded from the
//   PCSource                              state register (plus mem_ready where
//                                         a memory state completes)
//   state[3:0]                            current state encoding
//   instr_done, illegal_op                last-cycle / unknown-opcode flags
//   mem_timeout (sticky), halted          memory timeout handling
//   instr_count, cycle_count [CNT_W]      performance counters
// Build option: define MC_PERF_COUNT_EN to build the performance counters;
// otherwise both counter ports are tied to 0.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 255,
  parameter int WAIT_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  mc_state_e state_q, state_d;
  logic      mem_timeout_q, mem_timeout_d;
  logic      in_wait, wait_expire;

  assign in_wait = is_wait_state(state_q);

  // Held at zero except while stalling, so every wait state is entered with
  // a fresh count; a completing access clears it for the next wait state.
  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (~in_wait | mem_ready),
    .enable (in_wait & ~mem_ready),
    .expire (wait_expire)
  );

  always_comb begin
    state_d       = state_q;
    mem_timeout_d = mem_timeout_q | wait_expire;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_RT;
    ALUOp         = ALUOP_ADD;
    PCSource      = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)        state_d = S_DECODE;
        else if (wait_expire) state_d = S_HALT;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut.
        ALUSrcB = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            // Unknown opcode retires as a NOP.
            state_d    = S_FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)        state_d = S_MEMWB;
        else if (wait_expire) state_d = S_HALT;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready)        state_d = S_FETCH;
        else if (wait_expire) state_d = S_HALT;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;

`ifdef MC_PERF_COUNT_EN
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    cycle_count_d = cycle_count_q;
    if (instr_done) instr_count_d = instr_count_q + 1'b1;
    if ((state_q != S_IDLE) && (state_q != S_HALT)) cycle_count_d = cycle_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count_q <= '0;
      cycle_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign cycle_count = cycle_count_q;
`else
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multicycle control sequencer for the MIPS datapath: replaces the single-cycle opcode decoder with a Moore FSM that issues per-cycle datapath controls. Supports R-type, lw, sw, beq, j and addi. Shared instruction/data memory has variable latency, signalled by mem_ready. A wait timer halts the core on a memory timeout.

Parameters:
WAIT_MAX, 255, max consecutive wait cycles with mem_ready=0 in one memory state before timeout; 0 disables the timeout.
WAIT_W, 8, wait counter width; must satisfy WAIT_MAX < 2**WAIT_W.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
opcode  in  6  instr[31:26] from the instruction register
mem_ready  in  1  memory access completes this cycle
PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls
ALUSrcB  out  2  00=rt, 01=const 4, 10=sign-extended immediate, 11=sign-extended immediate<<2
ALUOp  out  2  00=add, 01=sub, 10=funct; feeds the existing ALU control decoder
PCSource  out  2  00=ALU result, 01=ALUOut register, 10=jump address
state  out  4  current state encoding
instr_done  out  1  high in the last cycle of each instruction
illegal_op  out  1  one-cycle pulse on an unknown opcode
mem_timeout  out  1  sticky; set when a memory wait times out
halted  out  1  high in state HALT
instr_count, cycle_count  out  CNT_W each  performance counters; see Optional Feature

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, mem_timeout=0, counters=0. All outputs are 0 in IDLE.
- Encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, HALT=13. Encodings 14 and 15 go to IDLE.
- Any control not listed for a state is 0.

State outputs and transitions:
- IDLE: no controls. Always -> FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. -> DECODE when mem_ready=1, else stay.
- DECODE: ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - any other -> FETCH, with illegal_op=1 and instr_done=1 this cycle (executes as NOP).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> MEMREAD if lw, MEMWRITE if sw.
- MEMREAD: MemRead=1, IorD=1. -> MEMWB on mem_ready=1.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. -> FETCH.
- MEMWRITE: MemWrite=1, IorD=1; instr_done=mem_ready. -> FETCH on mem_ready=1. MemWrite stays high for every wait cycle.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> ALUWB.
- ALUWB: RegDst=1, RegWrite=1, instr_done=1. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. -> FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
- ADDIWB: RegDst=0, RegWrite=1, instr_done=1. -> FETCH.
- HALT: all controls 0, halted=1. Exited only by reset.

Latency with mem_ready=1 (cycles from FETCH entry to next FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle adds 1.

Wait timer:
- Cleared on entry to FETCH, MEMREAD or MEMWRITE.
- Increments each cycle spent in those states with mem_ready=0.
- If mem_ready=0 when the counter equals WAIT_MAX-1 (WAIT_MAX>0): next state=HALT, mem_timeout set.
- mem_ready=1 in that same cycle wins: normal transition, no timeout.

Optional Feature:
Macro MC_PERF_COUNT_EN.
- Defined: cycle_count increments every cycle outside IDLE and HALT. instr_count increments on each cycle with instr_done=1. Both wrap modulo 2**CNT_W and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package mc_pkg: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), ALUOp/ALUSrcB/PCSource encodings.
- Sub-module mc_wait_timer (clear, enable, WAIT_MAX compare, expire flag), instantiated once.

Test Plan:
- lw, mem_ready tied 1, reset released -> states 0,1,2,3,4,5,1; RegWrite=1 and MemtoReg=1 only in state 5; instr_done pulses once.
- sw, mem_ready low 2 cycles in MEMWRITE -> state 6 held 3 cycles, MemWrite=1 all 3, instr_done only in the 3rd; next state 1.
- beq then j -> 1,2,9,1,2,10,1; PCWriteCond=1 in 9; PCWrite=1 with PCSource=10 in 10.
- Opcode 6'b111111 -> DECODE returns to FETCH; illegal_op=1 and instr_done=1 for one cycle; no RegWrite/MemWrite.
- WAIT_MAX=4, mem_ready=0 in FETCH -> HALT after 4 wait cycles; mem_timeout=1, halted=1 held until reset=0; repeat with mem_ready=1 on cycle 4 -> no timeout.
- reset=0 asserted mid-MEMREAD -> state=0 and all outputs 0 immediately; with MC_PERF_COUNT_EN, counters read 0, then instr_count=3 after three R-type instructions.
